// File: rtl/dot_matrix_pkg.sv
// Shared definitions for the dot-matrix cursor.
//   state_e        : controller states OFF / INIT / RUN
//   UP..LEFT       : bit positions of each direction in the 4-bit direction vector
//   NumDir         : width of the direction vector
package dot_matrix_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int unsigned NumDir = 4;

    localparam int unsigned UP    = 0;
    localparam int unsigned RIGHT = 1;
    localparam int unsigned DOWN  = 2;
    localparam int unsigned LEFT  = 3;

endpackage

// File: rtl/dot_matrix_btn_cond.sv
// Direction button conditioner: rising-edge (press) detection on the 4-bit direction
// vector, plus optional auto-repeat of a single held direction.
// Build option: define DOT_MATRIX_CURSOR_AUTOREPEAT_EN to include the auto-repeat logic.
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-high; clears press history and repeat counter
//   run_i     cursor is in RUN; strobes are suppressed and repeat cleared otherwise
//   dir_i     level direction inputs {left, down, right, up}
//   strobe_o  one-cycle move strobes, same bit order as dir_i
module dot_matrix_btn_cond
    import dot_matrix_pkg::*;
#(
    parameter int unsigned REPEAT_DLY = 16,
    parameter int unsigned REPEAT_PER = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_i,
    input  logic [NumDir-1:0] dir_i,
    output logic [NumDir-1:0] strobe_o
);

    if (REPEAT_PER < 1 || REPEAT_DLY < REPEAT_PER) begin : g_bad_repeat
        $error("dot_matrix_btn_cond: need 1 <= REPEAT_PER <= REPEAT_DLY");
    end

    logic [NumDir-1:0] prev_q;
    logic [NumDir-1:0] press;

    // Edge history runs in every state so a level held across OFF/INIT never
    // turns into a press once RUN is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= dir_i;
        end
    end

    assign press = dir_i & ~prev_q;

`ifdef DOT_MATRIX_CURSOR_AUTOREPEAT_EN
    localparam int unsigned CntW = $clog2(REPEAT_DLY + 1) + 1;
    localparam logic [CntW-1:0] CntFire   = CntW'(REPEAT_DLY);
    // Reloading here makes the next fire land exactly REPEAT_PER cycles later.
    localparam logic [CntW-1:0] CntReload = CntW'(REPEAT_DLY - REPEAT_PER + 1);

    // cnt_q holds the number of edges since the press; zero means idle.
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fire;

    always_comb begin
        cnt_d = '0;
        fire  = 1'b0;
        if (run_i && $onehot(dir_i)) begin
            if (press != '0) begin
                cnt_d = CntW'(1);
            end else if (cnt_q != '0 && dir_i == prev_q) begin
                if (cnt_q == CntFire) begin
                    fire  = 1'b1;
                    cnt_d = CntReload;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strobe_o = (press | (fire ? dir_i : '0)) & {NumDir{run_i}};
`else
    assign strobe_o = press & {NumDir{run_i}};
`endif

endmodule

// File: rtl/dot_matrix_cursor.sv
// Cursor on a ROWS x COLS LED dot matrix, steered by four direction buttons.
// Build option: DOT_MATRIX_CURSOR_AUTOREPEAT_EN enables auto-repeat of a held direction.
// Ports:
//   clk      clock, rising edge
//   reset    synchronous, active-high, priority over power
//   power    low forces OFF (LEDs dark, position held)
//   up/down/left/right  level direction inputs
//   leds     one-hot cursor image, bit row*COLS+col (all zero when OFF)
//   row/col  cursor position
//   moved    one-cycle pulse when the cursor changed
//   blocked  one-cycle pulse when a move was refused at an edge (WRAP=0 only)
module dot_matrix_cursor
    import dot_matrix_pkg::*;
#(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned WRAP       = 1,
    parameter int unsigned REPEAT_DLY = 16,
    parameter int unsigned REPEAT_PER = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     power,
    input  logic                     up,
    input  logic                     down,
    input  logic                     left,
    input  logic                     right,
    output logic [ROWS*COLS-1:0]     leds,
    output logic [$clog2(ROWS)-1:0]  row,
    output logic [$clog2(COLS)-1:0]  col,
    output logic                     moved,
    output logic                     blocked
);

    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned LedsW = ROWS * COLS;
    localparam logic [RW-1:0] RowMax = RW'(ROWS - 1);
    localparam logic [CW-1:0] ColMax = CW'(COLS - 1);

    if (ROWS < 2 || ROWS > 64 || COLS < 2 || COLS > 64 || WRAP > 1) begin : g_bad_size
        $error("dot_matrix_cursor: ROWS/COLS must be 2..64 and WRAP 0 or 1");
    end

    state_e             state_q, state_d;
    logic [RW-1:0]      row_q, row_d;
    logic [CW-1:0]      col_q, col_d;
    logic [LedsW-1:0]   leds_q, leds_d;
    logic               moved_q, moved_d;
    logic               blocked_q, blocked_d;
    logic [NumDir-1:0]  strobe;

    dot_matrix_btn_cond #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_btn_cond (
        .clk      (clk),
        .reset    (reset),
        .run_i    (state_q == RUN),
        .dir_i    ({left, down, right, up}),
        .strobe_o (strobe)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        leds_d    = leds_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;

        if (!power) begin
            state_d = OFF;
            leds_d  = '0;
        end else begin
            unique case (state_q)
                OFF: begin
                    state_d = INIT;
                    row_d   = '0;
                    col_d   = '0;
                    leds_d  = LedsW'(1);
                end
                INIT: begin
                    state_d = RUN;
                end
                RUN: begin
                    // Simultaneous strobes are ambiguous and ignored entirely.
                    if ($onehot(strobe)) begin
                        unique case (1'b1)
                            strobe[UP]: begin
                                if (row_q != '0) begin
                                    row_d = row_q - RW'(1);
                                    moved_d = 1'b1;
                                end else if (WRAP != 0) begin
                                    row_d = RowMax;
                                    moved_d = 1'b1;
                                end else begin
                                    blocked_d = 1'b1;
                                end
                            end
                            strobe[DOWN]: begin
                                if (row_q != RowMax) begin
                                    row_d = row_q + RW'(1);
                                    moved_d = 1'b1;
                                end else if (WRAP != 0) begin
                                    row_d = '0;
                                    moved_d = 1'b1;
                                end else begin
                                    blocked_d = 1'b1;
                                end
                            end
                            strobe[LEFT]: begin
                                if (col_q != '0) begin
                                    col_d = col_q - CW'(1);
                                    moved_d = 1'b1;
                                end else if (WRAP != 0) begin
                                    col_d = ColMax;
                                    moved_d = 1'b1;
                                end else begin
                                    blocked_d = 1'b1;
                                end
                            end
                            strobe[RIGHT]: begin
                                if (col_q != ColMax) begin
                                    col_d = col_q + CW'(1);
                                    moved_d = 1'b1;
                                end else if (WRAP != 0) begin
                                    col_d = '0;
                                    moved_d = 1'b1;
                                end else begin
                                    blocked_d = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    if (moved_d) begin
                        leds_d = LedsW'(1) << (32'(row_d) * COLS + 32'(col_d));
                    end
                end
                default: begin
                    state_d = OFF;
                    leds_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= OFF;
            row_q     <= '0;
            col_q     <= '0;
            leds_q    <= '0;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            leds_q    <= leds_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
        end
    end

    assign leds    = leds_q;
    assign row     = row_q;
    assign col     = col_q;
    assign moved   = moved_q;
    assign blocked = blocked_q;

endmodule

// File: tb/tb_dot_matrix_cursor.sv
// Bench for dot_matrix_cursor: three instances (4x4 wrap, 5x3 clamp, 8x8 wrap with
// repeat timing 16/4). Expectations are queued before each clock edge and checked
// one time unit after it.
module tb_dot_matrix_cursor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, power;
    logic [3:0] da, db, dc;  // {left, down, right, up}

    logic [15:0] leds_a;
    logic [1:0]  row_a, col_a;
    logic        moved_a, blocked_a;
    logic [14:0] leds_b;
    logic [2:0]  row_b;
    logic [1:0]  col_b;
    logic        moved_b, blocked_b;
    logic [63:0] leds_c;
    logic [2:0]  row_c, col_c;
    logic        moved_c, blocked_c;

    dot_matrix_cursor #(.ROWS(4), .COLS(4), .WRAP(1), .REPEAT_DLY(16), .REPEAT_PER(4)) u_a (
        .clk(clk), .reset(reset), .power(power),
        .up(da[0]), .down(da[2]), .left(da[3]), .right(da[1]),
        .leds(leds_a), .row(row_a), .col(col_a), .moved(moved_a), .blocked(blocked_a)
    );

    dot_matrix_cursor #(.ROWS(5), .COLS(3), .WRAP(0), .REPEAT_DLY(16), .REPEAT_PER(4)) u_b (
        .clk(clk), .reset(reset), .power(power),
        .up(db[0]), .down(db[2]), .left(db[3]), .right(db[1]),
        .leds(leds_b), .row(row_b), .col(col_b), .moved(moved_b), .blocked(blocked_b)
    );

    dot_matrix_cursor #(.ROWS(8), .COLS(8), .WRAP(1), .REPEAT_DLY(16), .REPEAT_PER(4)) u_c (
        .clk(clk), .reset(reset), .power(power),
        .up(dc[0]), .down(dc[2]), .left(dc[3]), .right(dc[1]),
        .leds(leds_c), .row(row_c), .col(col_c), .moved(moved_c), .blocked(blocked_c)
    );

    typedef struct {
        int    dut;
        int    row;
        int    col;
        bit    on;
        bit    mv;
        bit    bl;
        string tag;
    } exp_t;

    typedef struct {
        int         dut;
        logic [3:0] dir;
        int         row;
        int         col;
        bit         mv;
        bit         bl;
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic cmp(input string tag, input string what,
                       input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s %s: got 0x%0h, want 0x%0h", tag, what, act, req);
        end
    endtask

    task automatic check(input exp_t e);
        logic [63:0] al, ar, ac, el;
        logic        am, ab;
        int          cols;
        case (e.dut)
            0: begin
                al = 64'(leds_a); ar = 64'(row_a); ac = 64'(col_a);
                am = moved_a; ab = blocked_a; cols = 4;
            end
            1: begin
                al = 64'(leds_b); ar = 64'(row_b); ac = 64'(col_b);
                am = moved_b; ab = blocked_b; cols = 3;
            end
            default: begin
                al = leds_c; ar = 64'(row_c); ac = 64'(col_c);
                am = moved_c; ab = blocked_c; cols = 8;
            end
        endcase
        el = e.on ? (64'd1 << (e.row * cols + e.col)) : 64'd0;
        cmp(e.tag, "row", ar, 64'(e.row));
        cmp(e.tag, "col", ac, 64'(e.col));
        cmp(e.tag, "leds", al, el);
        cmp(e.tag, "moved", 64'(am), 64'(e.mv));
        cmp(e.tag, "blocked", 64'(ab), 64'(e.bl));
    endtask

    task automatic push(input int dut, input int r, input int c, input bit on,
                        input bit mv, input bit bl, input string tag);
        exp_t e;
        e.dut = dut; e.row = r; e.col = c; e.on = on; e.mv = mv; e.bl = bl; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        while (sb_q.size() != 0) check(sb_q.pop_front());
    endtask

    initial begin
        // Dut 0: 4x4 wrap, starting at (0,0)
        vt.push_back('{0, 4'b0001, 3, 0, 1, 0});  // up wraps to row 3
        vt.push_back('{0, 4'b0000, 3, 0, 0, 0});
        vt.push_back('{0, 4'b1000, 3, 3, 1, 0});  // left wraps to col 3
        vt.push_back('{0, 4'b0000, 3, 3, 0, 0});
        vt.push_back('{0, 4'b0010, 3, 0, 1, 0});  // right wraps to col 0
        vt.push_back('{0, 4'b0000, 3, 0, 0, 0});
        vt.push_back('{0, 4'b0100, 0, 0, 1, 0});  // down wraps to row 0
        vt.push_back('{0, 4'b0000, 0, 0, 0, 0});
        vt.push_back('{0, 4'b0100, 1, 0, 1, 0});
        vt.push_back('{0, 4'b0100, 1, 0, 0, 0});  // held, no new press
        vt.push_back('{0, 4'b0000, 1, 0, 0, 0});
        vt.push_back('{0, 4'b0011, 1, 0, 0, 0});  // up+right together ignored
        vt.push_back('{0, 4'b0011, 1, 0, 0, 0});
        vt.push_back('{0, 4'b0000, 1, 0, 0, 0});
        vt.push_back('{0, 4'b0010, 1, 1, 1, 0});
        vt.push_back('{0, 4'b0000, 1, 1, 0, 0});
        vt.push_back('{0, 4'b0001, 0, 1, 1, 0});
        vt.push_back('{0, 4'b0011, 0, 2, 1, 0});  // right pressed while up held
        vt.push_back('{0, 4'b0000, 0, 2, 0, 0});
        vt.push_back('{0, 4'b1000, 0, 1, 1, 0});
        vt.push_back('{0, 4'b0000, 0, 1, 0, 0});
        vt.push_back('{0, 4'b0100, 1, 1, 1, 0});
        vt.push_back('{0, 4'b0000, 1, 1, 0, 0});
        vt.push_back('{0, 4'b0100, 2, 1, 1, 0});
        vt.push_back('{0, 4'b0000, 2, 1, 0, 0});
        // Dut 1: 5x3 clamp, starting at (0,0)
        vt.push_back('{1, 4'b0001, 0, 0, 0, 1});  // up at row 0 refused
        vt.push_back('{1, 4'b0000, 0, 0, 0, 0});
        vt.push_back('{1, 4'b0100, 1, 0, 1, 0});
        vt.push_back('{1, 4'b0000, 1, 0, 0, 0});
        vt.push_back('{1, 4'b0100, 2, 0, 1, 0});
        vt.push_back('{1, 4'b0000, 2, 0, 0, 0});
        vt.push_back('{1, 4'b0100, 3, 0, 1, 0});
        vt.push_back('{1, 4'b0000, 3, 0, 0, 0});
        vt.push_back('{1, 4'b0100, 4, 0, 1, 0});
        vt.push_back('{1, 4'b0000, 4, 0, 0, 0});
        vt.push_back('{1, 4'b0010, 4, 1, 1, 0});
        vt.push_back('{1, 4'b0000, 4, 1, 0, 0});
        vt.push_back('{1, 4'b0010, 4, 2, 1, 0});
        vt.push_back('{1, 4'b0000, 4, 2, 0, 0});
        vt.push_back('{1, 4'b0100, 4, 2, 0, 1});  // down at last row refused
        vt.push_back('{1, 4'b0000, 4, 2, 0, 0});
        vt.push_back('{1, 4'b0010, 4, 2, 0, 1});  // right at last col refused
        vt.push_back('{1, 4'b0000, 4, 2, 0, 0});
        vt.push_back('{1, 4'b1000, 4, 1, 1, 0});
        vt.push_back('{1, 4'b0000, 4, 1, 0, 0});
        vt.push_back('{1, 4'b0001, 3, 1, 1, 0});
        vt.push_back('{1, 4'b0000, 3, 1, 0, 0});

        reset = 1'b1; power = 1'b1; da = '0; db = '0; dc = '0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) push(d, 0, 0, 0, 0, 0, "reset");
        tick();

        // Reset release: INIT then RUN, cursor at (0,0)
        reset = 1'b0;
        for (int d = 0; d < 3; d++) push(d, 0, 0, 1, 0, 0, "init");
        tick();
        for (int d = 0; d < 3; d++) push(d, 0, 0, 1, 0, 0, "run");
        tick();

        for (int i = 0; i < vt.size(); i++) begin
            da = '0; db = '0; dc = '0;
            case (vt[i].dut)
                0:       da = vt[i].dir;
                1:       db = vt[i].dir;
                default: dc = vt[i].dir;
            endcase
            push(vt[i].dut, vt[i].row, vt[i].col, 1, vt[i].mv, vt[i].bl,
                 $sformatf("vec%0d", i));
            tick();
        end
        da = '0; db = '0; dc = '0;

        // Power drop at (2,1): dark, position held, presses discarded; restore re-inits
        power = 1'b0;
        push(0, 2, 1, 0, 0, 0, "pwr_off");
        tick();
        da = 4'b0100;
        push(0, 2, 1, 0, 0, 0, "off_press");
        tick();
        da = '0; power = 1'b1;
        push(0, 0, 0, 1, 0, 0, "pwr_init");
        push(2, 0, 0, 1, 0, 0, "pwr_init_c");
        tick();
        push(0, 0, 0, 1, 0, 0, "pwr_run");
        push(2, 0, 0, 1, 0, 0, "pwr_run_c");
        tick();

        // Hold right on the 8x8 for 30 cycles
        begin
            int exp_col = 0;
            dc = 4'b0010;
            for (int i = 0; i < 30; i++) begin
                bit mv;
                mv = (i == 0);
`ifdef DOT_MATRIX_CURSOR_AUTOREPEAT_EN
                if (i >= 16 && ((i - 16) % 4) == 0) mv = 1'b1;
`endif
                if (mv) exp_col++;
                push(2, 0, exp_col, 1, mv, 0, $sformatf("hold%0d", i));
                tick();
            end
        end

        // Reset while still holding: repeat aborted, held level is not a fresh press
        reset = 1'b1;
        push(0, 0, 0, 0, 0, 0, "rst_mid_a");
        push(2, 0, 0, 0, 0, 0, "rst_mid_c");
        tick();
        reset = 1'b0;
        push(2, 0, 0, 1, 0, 0, "rst_init");
        tick();
        push(2, 0, 0, 1, 0, 0, "rst_run");
        tick();
        for (int i = 0; i < 20; i++) begin
            push(2, 0, 0, 1, 0, 0, $sformatf("after_rst%0d", i));
            tick();
        end
        dc = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
